// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment driver: latches a packed hex value, walks the digit
// enables at SCAN_DIV clocks per slot with one dead cycle between digits.
module seven_seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 25000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Load,
    input  logic                    Blank,
    output logic [6:0]              Segment,
    output logic [NUM_DIGITS-1:0]   Digit_En,
    output logic                    Scan_Tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{ACTIVE_LOW != 0}};

    typedef enum logic {ST_DEAD = 1'b0, ST_ON = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   en_hi;
    logic                    zero_run;
    logic [3:0]              nib_p0;
    logic                    lz_p0;
    logic [6:0]              seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0]   en_p0, en_p1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h77;
            4'hB: return 7'h1F;
            4'hC: return 7'h4E;
            4'hD: return 7'h3D;
            4'hE: return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    function automatic logic [6:0] pol_seg(input logic [6:0] s);
        return (ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] pol_en(input logic [NUM_DIGITS-1:0] e);
        return (ACTIVE_LOW != 0) ? ~e : e;
    endfunction

    assign Scan_Tick = (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (Scan_Tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Index starts on the last digit so the first tick lands on digit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx <= IDX_LAST;
        end else if (Scan_Tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow <= '0;
        end else if (Load) begin
            shadow <= Value;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_DEAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Every tick forces one dead cycle so the digit change is never visible.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DEAD: state_nxt = Scan_Tick ? ST_DEAD : ST_ON;
            ST_ON:   state_nxt = Scan_Tick ? ST_DEAD : ST_ON;
            default: state_nxt = ST_DEAD;
        endcase
    end

    // upper_zero[i]: nibbles NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (shadow[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
        nib_p0 = 4'h0;
        lz_p0  = 1'b0;
        en_hi  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_p0   = shadow[4*i +: 4];
                lz_p0    = (BLANK_LZ != 0) && (i != 0) && upper_zero[i];
                en_hi[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_p0 = SEG_OFF;
        en_p0  = EN_OFF;
        if (state_nxt == ST_ON && !Blank) begin
            en_p0  = pol_en(en_hi);
            seg_p0 = lz_p0 ? SEG_OFF : pol_seg(hex_to_seg(nib_p0));
        end
    end

    // p0 -> p1: registered pin drivers
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_p1 <= SEG_OFF;
            en_p1  <= EN_OFF;
        end else begin
            seg_p1 <= seg_p0;
            en_p1  <= en_p0;
        end
    end

    assign Segment  = seg_p1;
    assign Digit_En = en_p1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: four parameter sets share one random stimulus and are
// checked every cycle against a cycle-count based reference model.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Load = 1'b0;
    logic        Blank = 1'b0;
    logic [15:0] Value = 16'h0;

    logic [6:0] seg0, seg1, seg2, seg3;
    logic [3:0] en0, en1, en2;
    logic [0:0] en3;
    logic       tk0, tk1, tk2, tk3;

    int vectors = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut0 (
        .CLK(CLK), .RST(RST), .Value(Value), .Load(Load), .Blank(Blank),
        .Segment(seg0), .Digit_En(en0), .Scan_Tick(tk0));
    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut1 (
        .CLK(CLK), .RST(RST), .Value(Value), .Load(Load), .Blank(Blank),
        .Segment(seg1), .Digit_En(en1), .Scan_Tick(tk1));
    seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut2 (
        .CLK(CLK), .RST(RST), .Value(Value), .Load(Load), .Blank(Blank),
        .Segment(seg2), .Digit_En(en2), .Scan_Tick(tk2));
    seven_seg_scan #(.NUM_DIGITS(1), .SCAN_DIV(3), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut3 (
        .CLK(CLK), .RST(RST), .Value(Value[3:0]), .Load(Load), .Blank(Blank),
        .Segment(seg3), .Digit_En(en3), .Scan_Tick(tk3));

    localparam int ND [4] = '{4, 4, 4, 1};
    localparam int SD [4] = '{4, 4, 4, 3};
    localparam int AL [4] = '{0, 1, 0, 1};
    localparam int LZ [4] = '{1, 1, 0, 1};

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: cycles since reset, shadow value, expected registered outputs.
    int         n = 0;
    logic [15:0] shadow = 16'h0;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_en [4];
    bit         chk_en = 1'b0;

    function automatic logic [3:0] en_mask(input int k);
        return 4'((1 << ND[k]) - 1);
    endfunction

    function automatic logic [6:0] seg_off(input int k);
        return (AL[k] != 0) ? 7'h7F : 7'h00;
    endfunction

    function automatic logic [3:0] en_off(input int k);
        return (AL[k] != 0) ? en_mask(k) : 4'h0;
    endfunction

    function automatic bit is_tick(input int k, input int cyc);
        return (cyc % SD[k]) == SD[k] - 1;
    endfunction

    function automatic int cur_digit(input int k, input int cyc);
        return (ND[k] - 1 + cyc / SD[k]) % ND[k];
    endfunction

    function automatic logic [6:0] model_seg(input int k, input int cyc, input logic [15:0] sh,
                                             input logic blk);
        int          d;
        logic [15:0] m;
        logic [15:0] upper;
        logic [6:0]  s;
        d = cur_digit(k, cyc);
        m = sh & 16'((32'd1 << (4 * ND[k])) - 1);
        upper = m >> (4 * d);
        if (is_tick(k, cyc) || blk) s = 7'h00;
        else if (LZ[k] != 0 && d > 0 && upper == 16'h0) s = 7'h00;
        else s = seg_tab[int'(upper & 16'hF)];
        return (AL[k] != 0) ? ~s : s;
    endfunction

    function automatic logic [3:0] model_en(input int k, input int cyc, input logic blk);
        logic [3:0] e;
        if (is_tick(k, cyc) || blk) e = 4'h0;
        else e = 4'(1 << cur_digit(k, cyc));
        return (AL[k] != 0) ? (e ^ en_mask(k)) : e;
    endfunction

    always @(posedge CLK) begin
        chk_en <= 1'b1;
        if (RST) begin
            n <= 0;
            shadow <= 16'h0;
            for (int k = 0; k < 4; k++) begin
                exp_seg[k] <= seg_off(k);
                exp_en[k]  <= en_off(k);
            end
        end else begin
            n <= n + 1;
            if (Load) shadow <= Value;
            for (int k = 0; k < 4; k++) begin
                exp_seg[k] <= model_seg(k, n, shadow, Blank);
                exp_en[k]  <= model_en(k, n, Blank);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("seg0", 32'(seg0), 32'(exp_seg[0]));
            chk("en0", 32'(en0), 32'(exp_en[0]));
            chk("tick0", 32'(tk0), 32'(is_tick(0, n)));
            chk("seg1", 32'(seg1), 32'(exp_seg[1]));
            chk("en1", 32'(en1), 32'(exp_en[1]));
            chk("tick1", 32'(tk1), 32'(is_tick(1, n)));
            chk("seg2", 32'(seg2), 32'(exp_seg[2]));
            chk("en2", 32'(en2), 32'(exp_en[2]));
            chk("tick2", 32'(tk2), 32'(is_tick(2, n)));
            chk("seg3", 32'(seg3), 32'(exp_seg[3]));
            chk("en3", 32'(en3), 32'(exp_en[3][0]));
            chk("tick3", 32'(tk3), 32'(is_tick(3, n)));
        end
    end

    task automatic wait_tick(input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (tk0) found = 1'b1;
        end
        if (!found) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_digit(input string nm, input int which, input logic [3:0] en,
                              input logic [6:0] seg);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (which == 0 && en0 == en) begin
                found = 1'b1;
                chk(nm, 32'(seg0), 32'(seg));
            end else if (which == 2 && en2 == en) begin
                found = 1'b1;
                chk(nm, 32'(seg2), 32'(seg));
            end
        end
        if (!found) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v);
        Value = v;
        Load = 1'b1;
        @(negedge CLK);
        Load = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int dly;
        int ticks;

        // Reset levels
        repeat (3) @(negedge CLK);
        chk("rst_en0", 32'(en0), 32'h0);
        chk("rst_seg0", 32'(seg0), 32'h00);
        chk("rst_en1", 32'(en1), 32'hF);
        chk("rst_seg1", 32'(seg1), 32'h7F);

        // Release with a load of 1234; first tick on the 4th cycle after reset
        RST = 1'b0;
        Value = 16'h1234;
        Load = 1'b1;
        @(negedge CLK);
        Load = 1'b0;
        dly = 1;
        while (!tk0 && dly < 10) begin
            @(negedge CLK);
            dly++;
        end
        chk("first_tick_cycle", 32'(dly), 32'd3);
        @(negedge CLK);
        chk("dead_en0", 32'(en0), 32'h0);
        chk("dead_seg0", 32'(seg0), 32'h00);
        @(negedge CLK);
        chk("d0_en0", 32'(en0), 32'h1);
        chk("d0_seg0", 32'(seg0), 32'h33);
        chk("d0_en1", 32'(en1), 32'hE);
        chk("d0_seg1", 32'(seg1), 32'h4C);

        // Scan order
        wait_digit("scan_d1", 0, 4'b0010, 7'h79);
        wait_digit("scan_d2", 0, 4'b0100, 7'h6D);
        wait_digit("scan_d3", 0, 4'b1000, 7'h30);
        wait_digit("scan_wrap", 0, 4'b0001, 7'h33);

        // Leading-zero suppression
        load_val(16'h0070);
        wait_digit("lz_d0", 0, 4'b0001, 7'h7E);
        wait_digit("lz_d1", 0, 4'b0010, 7'h70);
        wait_digit("lz_d2", 0, 4'b0100, 7'h00);
        wait_digit("lz_d3", 0, 4'b1000, 7'h00);
        load_val(16'h0000);
        wait_digit("zero_d0", 0, 4'b0001, 7'h7E);
        wait_digit("zero_d1", 0, 4'b0010, 7'h00);
        wait_digit("nolz_d3", 2, 4'b1000, 7'h7E);

        // Value change without Load is ignored
        Value = 16'hFFFF;
        repeat (2) @(negedge CLK);
        wait_digit("noload_d0", 0, 4'b0001, 7'h7E);

        // Load on a tick cycle
        wait_tick("load_tick");
        Value = 16'hFFFF;
        Load = 1'b1;
        @(negedge CLK);
        Load = 1'b0;
        chk("lt_dead_en0", 32'(en0), 32'h0);
        @(negedge CLK);
        chk("lt_seg0", 32'(seg0), 32'h47);

        // Blank for 10 cycles
        Blank = 1'b1;
        ticks = 0;
        repeat (10) begin
            @(negedge CLK);
            chk("blank_en0", 32'(en0), 32'h0);
            chk("blank_seg0", 32'(seg0), 32'h00);
            if (tk0) ticks++;
        end
        Blank = 1'b0;
        chk("blank_ticks", 32'(ticks >= 2), 32'd1);

        // Reset during digit 2
        wait_digit("pre_rst_d2", 0, 4'b0100, 7'h47);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_en0", 32'(en0), 32'h0);
        chk("mid_rst_seg0", 32'(seg0), 32'h00);
        chk("mid_rst_en1", 32'(en1), 32'hF);
        chk("mid_rst_seg1", 32'(seg1), 32'h7F);
        RST = 1'b0;
        wait_digit("post_rst_d0", 0, 4'b0001, 7'h7E);

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge CLK);
            Load  = ($urandom % 4) == 0;
            Value = 16'($urandom);
            if (($urandom % 3) == 0) Value = Value >> (4 * ($urandom % 4));
            Blank = ($urandom % 10) == 0;
            RST   = ($urandom % 300) == 0;
        end
        @(negedge CLK);
        RST = 1'b0;
        Load = 1'b0;
        Blank = 1'b0;
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for a bank of `NUM_DIGITS` common-anode or common-cathode 7-segment digits that share one set of segment lines. It latches a packed hex value, walks the digit enables at a programmable scan rate with a one-cycle dead time between digits, and decodes each nibble to segments. Optional leading-zero suppression and a global blank are provided. It sits between board-level logic producing numbers (counters, switch readers) and the display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits, 1..8.
- `SCAN_DIV`, 25000: clocks per digit slot, ≥ 2.
- `ACTIVE_LOW`, 1: 1 inverts `Segment` and `Digit_En` at the pins.
- `BLANK_LZ`, 1: 1 enables leading-zero suppression.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Value` in 4*NUM_DIGITS: packed hex digits; nibble i (`Value[4i+3:4i]`) belongs to digit i, and digit 0 is the least significant.
- `Load` in 1: captures `Value` into the shadow register on this edge.
- `Blank` in 1: forces the display dark while high.
- `Segment` out 7: {A,B,C,D,E,F,G}, with A at bit 6; polarity-applied.
- `Digit_En` out NUM_DIGITS: one-hot digit select; polarity-applied.
- `Scan_Tick` out 1: single-cycle pulse when the prescaler reaches its terminal count.

## Operation
- **Shadow register.** The shadow register resets to 0. It loads only on `Load`. `Value` changes without `Load` have no effect.
- **Prescaler.**
  - Counts 0..SCAN_DIV-1 and wraps.
  - `Scan_Tick` = (prescaler == SCAN_DIV-1).
- **Digit index.**
  - Resets to NUM_DIGITS-1.
  - On each tick it advances by 1 modulo NUM_DIGITS, so NUM_DIGITS-1 wraps to 0. The first tick after reset therefore selects digit 0.
- **State machine (2 states).**
  - DEAD: all enables inactive, segments off.
  - ON: enable = one-hot(index), segments = decode.
  - Reset enters DEAD.
  - A tick in either state → DEAD for the following cycle. Index is updated on the same edge.
  - DEAD with no tick → ON.
- **Decode table, active-high** (nibble: value):
  - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70
  - 8:7F, 9:7B, A:77, B:1F, C:4E, D:3D, E:4F, F:47
- **Leading-zero suppression** (`BLANK_LZ`=1):
  - Digit i>0 is blanked (segments off, enable still asserted) when shadow nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never suppressed, so value 0 shows "0".
- **Blank.** While `Blank` is high, the ON state outputs all enables inactive and segments off. Prescaler and index keep running.
- **Polarity.** `ACTIVE_LOW`=1 inverts both output buses. "Off/inactive" means pin level 1.

## Timing
- **Registered outputs.** `Segment` and `Digit_En` are registered. In ON, they reflect the shadow register and index as of the previous cycle. `Scan_Tick` is combinational from the prescaler.
- **Tick sequence.** Tick at cycle t → DEAD outputs at t+1 → new digit ON at t+2.
- **Load latency.** A `Load` at cycle L is visible on `Segment` at L+2, provided the display is in ON.
- **Load and tick in the same cycle.** The shadow and index both update. The dead cycle hides the transition, and the new digit shows the new value at t+2.
- **Blank latency.** `Blank` asserted at cycle b → dark from b+1. Deasserted at cycle b → the current digit reappears at b+1.
- **Reset values.**
  - Prescaler 0, index NUM_DIGITS-1, shadow 0, state DEAD, `Scan_Tick` 0.
  - `Segment` off: 7'h00, or 7'h7F when `ACTIVE_LOW`=1.
  - `Digit_En` inactive.
- **Reset mid-scan.** Outputs go to reset values on the next edge. The first tick occurs SCAN_DIV cycles after the release edge.
- **NUM_DIGITS=1.** Index stays 0. Each tick still produces one dead cycle.

## Test plan
Bench settings: NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0, BLANK_LZ=1, unless stated otherwise.

1. **Reset.** Hold RST for 3 cycles → `Digit_En`=0000, `Segment`=00. After release: tick on the 4th cycle, one dead cycle, then `Digit_En`=0001.
2. **Scan order.** Load 16'h1234 → the slots show 0001/33, 0010/79, 0100/6D, 1000/30, then wrap to 0001/33. Each slot is 3 ON cycles plus 1 dead cycle.
3. **Leading zeros.**
   - 16'h0070 → digit0 7E, digit1 70, digits 2–3 enabled with `Segment`=00.
   - 16'h0000 → digit0 7E only.
   - With BLANK_LZ=0 and 16'h0000 → 7E on every digit.
4. **Polarity.** ACTIVE_LOW=1 with 16'h1234 → digit0 shows `Digit_En`=1110, `Segment`=7'h4C. Reset levels are 1111/7F.
5. **Load timing.**
   - Change `Value` without `Load` → display unchanged.
   - `Load` of 16'hFFFF on a tick cycle → the next ON slot shows 47.
6. **Blank and mid-scan reset.**
   - `Blank` for 10 cycles → enables 0000, segments 00, `Scan_Tick` continues.
   - RST during digit2 → outputs return to reset values next edge; a 0001 slot follows.
